// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, strobe bit map and microstep encodings
package cpu_pkg;

    localparam int CTRL_W = 12;

    // Bit positions inside o_ctrl_n; every strobe is active low.
    localparam int PC_READ   = 0;
    localparam int PC_WRITE  = 1;
    localparam int PC_INC    = 2;
    localparam int MAR_WRITE = 3;
    localparam int RAM_READ  = 4;
    localparam int IR_READ   = 5;
    localparam int IR_WRITE  = 6;
    localparam int A_READ    = 7;
    localparam int A_WRITE   = 8;
    localparam int B_WRITE   = 9;
    localparam int ALU_READ  = 10;
    localparam int OUT_WRITE = 11;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    // All-ones word with a single strobe pulled low; AND several together.
    function automatic logic [CTRL_W-1:0] strobe_n(input int idx);
        return ~(CTRL_W'(1) << idx);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - advance/last/step handshake between decode and step counter
interface control_sequencer_if;
    import cpu_pkg::*;

    logic  advance;
    logic  last;
    step_t step;

    modport master (output advance, output last, input step);
    modport slave  (input advance, input last, output step);

endinterface

// File: rtl/step_counter.sv
// rtl/step_counter.sv - microstep register with last-step clear and enable hold
module step_counter
    import cpu_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset_n,
    control_sequencer_if.slave  ctl
);

    step_t step_q;
    step_t step_nxt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            step_q <= T0;
        end else begin
            step_q <= step_nxt;
        end
    end

    always_comb begin
        step_nxt = step_q;
        if (ctl.advance) begin
            if (ctl.last) begin
                step_nxt = T0;
            end else begin
                step_nxt = step_t'(step_q + 3'd1);
            end
        end
    end

    assign ctl.step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded control sequencer; STEP_MODE_EN adds single-instruction stepping
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_enable,
`ifdef STEP_MODE_EN
    input  logic                i_step,
`endif
    input  logic [OPCODE_W-1:0] i_opcode,
    output logic [CTRL_W-1:0]   o_ctrl_n,
    output logic [2:0]          o_step,
    output logic                o_halted
);

    control_sequencer_if ctl ();

    logic              halted;
    logic              run_ok;
    logic              active;
    logic              last;
    logic [CTRL_W-1:0] ctrl_n;

`ifdef STEP_MODE_EN
    logic step_q;
    logic armed;

    // armed covers exactly one instruction: set by an i_step rise while idle at T0,
    // cleared on the edge that ends the instruction's last step.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            step_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            step_q <= i_step;
            if (!armed && !halted && i_step && !step_q) begin
                armed <= 1'b1;
            end else if (active && last) begin
                armed <= 1'b0;
            end
        end
    end

    assign run_ok = armed;
`else
    assign run_ok = 1'b1;
`endif

    assign active      = i_reset_n && i_enable && !halted && run_ok;
    assign ctl.advance = active;
    assign ctl.last    = last;

    step_counter u_step_counter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .ctl       (ctl)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            halted <= 1'b0;
        end else if (active && ctl.step == T2 && i_opcode == OPCODE_W'(OP_HLT)) begin
            halted <= 1'b1;
        end
    end

    // Opcode is only consulted from T2 on; fetch never looks at it.
    always_comb begin
        ctrl_n = '1;
        last   = 1'b0;
        case (ctl.step)
            T0: ctrl_n = strobe_n(PC_READ) & strobe_n(MAR_WRITE);
            T1: ctrl_n = strobe_n(RAM_READ) & strobe_n(IR_WRITE) & strobe_n(PC_INC);
            T2: begin
                case (i_opcode)
                    OPCODE_W'(OP_LDA),
                    OPCODE_W'(OP_ADD): ctrl_n = strobe_n(IR_READ) & strobe_n(MAR_WRITE);
                    OPCODE_W'(OP_JMP): begin
                        ctrl_n = strobe_n(IR_READ) & strobe_n(PC_WRITE);
                        last   = 1'b1;
                    end
                    OPCODE_W'(OP_OUT): begin
                        ctrl_n = strobe_n(A_READ) & strobe_n(OUT_WRITE);
                        last   = 1'b1;
                    end
                    OPCODE_W'(OP_NOP),
                    OPCODE_W'(OP_HLT): last = 1'b1;
                    default:           last = 1'b1;
                endcase
            end
            T3: begin
                case (i_opcode)
                    OPCODE_W'(OP_LDA): begin
                        ctrl_n = strobe_n(RAM_READ) & strobe_n(A_WRITE);
                        last   = 1'b1;
                    end
                    OPCODE_W'(OP_ADD): ctrl_n = strobe_n(RAM_READ) & strobe_n(B_WRITE);
                    default:           last = 1'b1;
                endcase
            end
            T4: begin
                if (i_opcode == OPCODE_W'(OP_ADD)) begin
                    ctrl_n = strobe_n(ALU_READ) & strobe_n(A_WRITE);
                end
                last = 1'b1;
            end
            default: last = 1'b1;
        endcase
    end

    assign o_ctrl_n = active ? ctrl_n : '1;
    assign o_step   = ctl.step;
    assign o_halted = halted;

endmodule
